// File: rtl/multi_digit_counter.sv
// multi_digit_counter: cascaded up/down digit counter with load, wrap/saturate and carry pulses
module multi_digit_counter #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_WIDTH = 4,
  parameter int DIGIT_MAX   = 9,
  parameter int SATURATE    = 0
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              ENABLE_IN,
  input  logic                              DIR_DOWN,
  input  logic                              LOAD,
  input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] LOAD_VALUE,
  output logic [NUM_DIGITS*DIGIT_WIDTH-1:0] COUNT,
  output logic [NUM_DIGITS-1:0]             DIGIT_TRIGG,
  output logic                              TRIGG_OUT,
  output logic                              AT_LIMIT
);
  localparam logic [DIGIT_WIDTH-1:0] DMAX = DIGIT_WIDTH'(DIGIT_MAX);
  logic [NUM_DIGITS:0] c;
  logic [NUM_DIGITS-1:0] at_max, at_zero;
  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] next_count, clamped;
  logic sat_hold;
  assign c[0] = 1'b1;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [DIGIT_WIDTH-1:0] d, lv;
    assign d = COUNT[k*DIGIT_WIDTH +: DIGIT_WIDTH];
    assign lv = LOAD_VALUE[k*DIGIT_WIDTH +: DIGIT_WIDTH];
    assign at_max[k] = d == DMAX;
    assign at_zero[k] = d == '0;
    assign c[k+1] = c[k] & (DIR_DOWN ? at_zero[k] : at_max[k]);
    assign next_count[k*DIGIT_WIDTH +: DIGIT_WIDTH] = !c[k] ? d :
      DIR_DOWN ? (at_zero[k] ? DMAX : d - 1'b1) : (at_max[k] ? '0 : d + 1'b1);
    assign clamped[k*DIGIT_WIDTH +: DIGIT_WIDTH] = lv > DMAX ? DMAX : lv;
  end
  assign AT_LIMIT = DIR_DOWN ? &at_zero : &at_max;
  // a carry out of the top digit is exactly the full-scale wrap that saturation blocks
  assign sat_hold = (SATURATE != 0) && c[NUM_DIGITS];
  always_ff @(posedge CLK) begin
    if (RESET) begin
      COUNT       <= '0;
      DIGIT_TRIGG <= '0;
      TRIGG_OUT   <= 1'b0;
    end else if (LOAD) begin
      COUNT       <= clamped;
      DIGIT_TRIGG <= '0;
      TRIGG_OUT   <= 1'b0;
    end else if (ENABLE_IN) begin
      COUNT       <= sat_hold ? COUNT : next_count;
      DIGIT_TRIGG <= sat_hold ? '0 : c[NUM_DIGITS:1];
      TRIGG_OUT   <= c[NUM_DIGITS];
    end else begin
      DIGIT_TRIGG <= '0;
      TRIGG_OUT   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multi_digit_counter.sv
// tb_multi_digit_counter: table, hand-sequence and randomized model checks of wrap and saturate builds
module tb_multi_digit_counter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int B = 10;
  localparam int FULL = B ** N;
  logic clk = 0, rst = 0, en = 0, dn = 0, ld = 0;
  logic [N*W-1:0] lv = '0;
  logic [N*W-1:0] cnt_w, cnt_s;
  logic [N-1:0] dt_w, dt_s;
  logic t_w, t_s, lim_w, lim_s;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  multi_digit_counter #(.NUM_DIGITS(N), .DIGIT_WIDTH(W), .DIGIT_MAX(B-1), .SATURATE(0)) dut_w (
    .CLK(clk), .RESET(rst), .ENABLE_IN(en), .DIR_DOWN(dn), .LOAD(ld), .LOAD_VALUE(lv),
    .COUNT(cnt_w), .DIGIT_TRIGG(dt_w), .TRIGG_OUT(t_w), .AT_LIMIT(lim_w));
  multi_digit_counter #(.NUM_DIGITS(N), .DIGIT_WIDTH(W), .DIGIT_MAX(B-1), .SATURATE(1)) dut_s (
    .CLK(clk), .RESET(rst), .ENABLE_IN(en), .DIR_DOWN(dn), .LOAD(ld), .LOAD_VALUE(lv),
    .COUNT(cnt_s), .DIGIT_TRIGG(dt_s), .TRIGG_OUT(t_s), .AT_LIMIT(lim_s));
  typedef struct {
    logic r, l, e, d;
    logic [15:0] lv, c;
    logic [3:0] dt;
    logic t, lim;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic l, input logic e, input logic d, input logic [15:0] v);
    rst = r; ld = l; en = e; dn = d; lv = v;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] pack(input int v);
    logic [15:0] p;
    for (int k = 0; k < N; k++) p[k*W +: W] = W'((v / (B ** k)) % B);
    return p;
  endfunction
  function automatic int clamp_val(input logic [15:0] p);
    int v = 0;
    for (int k = 0; k < N; k++) begin
      int f = int'(p[k*W +: W]);
      v += (f > B - 1 ? B - 1 : f) * (B ** k);
    end
    return v;
  endfunction
  // counter value held as an integer; digit carries derived from modular arithmetic
  task automatic model(input bit sat, inout int v, output logic [3:0] dt, output logic t);
    dt = '0;
    t = 0;
    if (rst) v = 0;
    else if (ld) v = clamp_val(lv);
    else if (en) begin
      bit wraps = dn ? (v == 0) : (v == FULL - 1);
      t = wraps;
      if (!(sat && wraps)) begin
        for (int k = 0; k < N; k++) begin
          int m = B ** (k + 1);
          dt[k] = dn ? (v % m == 0) : (v % m == m - 1);
        end
        v = dn ? (v + FULL - 1) % FULL : (v + 1) % FULL;
      end
    end
  endtask
  initial begin
    int vw, vs;
    logic [3:0] edw, eds;
    logic etw, ets;
    tbl[0]  = '{1, 0, 0, 0, 16'h0000, 16'h0000, 4'h0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 16'h9999, 16'h9999, 4'h0, 0, 1};
    tbl[2]  = '{0, 0, 1, 0, 16'h0000, 16'h0000, 4'hF, 1, 0};
    tbl[3]  = '{0, 1, 0, 0, 16'h0100, 16'h0100, 4'h0, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 16'h0000, 16'h0099, 4'h3, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 16'h0A3F, 16'h0939, 4'h0, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 16'h0123, 16'h0123, 4'h0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 16'h0000, 16'h0123, 4'h0, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 16'h9999, 16'h9999, 4'h0, 0, 1};
    tbl[9]  = '{1, 1, 1, 0, 16'h9999, 16'h0000, 4'h0, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 16'h0000, 16'h0000, 4'h0, 0, 1};
    tbl[11] = '{0, 0, 1, 1, 16'h0000, 16'h9999, 4'hF, 1, 0};
    tbl[12] = '{0, 0, 1, 1, 16'h0000, 16'h9998, 4'h0, 0, 0};
    tbl[13] = '{0, 0, 1, 0, 16'h0000, 16'h9999, 4'h0, 0, 1};
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r, tbl[i].l, tbl[i].e, tbl[i].d, tbl[i].lv);
      chk($sformatf("tbl%0d count", i), 32'(cnt_w), 32'(tbl[i].c));
      chk($sformatf("tbl%0d digit_trigg", i), 32'(dt_w), 32'(tbl[i].dt));
      chk($sformatf("tbl%0d trigg_out", i), 32'(t_w), 32'(tbl[i].t));
      chk($sformatf("tbl%0d at_limit", i), 32'(lim_w), 32'(tbl[i].lim));
    end
    drive(1, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 1, 0, 16'h0);
      chk($sformatf("up%0d count", i), 32'(cnt_w), i == 10 ? 32'h10 : 32'(i));
      chk($sformatf("up%0d digit_trigg", i), 32'(dt_w), i == 10 ? 32'h1 : 32'h0);
    end
    drive(0, 0, 0, 0, 16'h0);
    chk("up pulse drop", 32'(dt_w), 32'h0);
    drive(0, 1, 0, 0, 16'h9999);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 16'h0);
      chk($sformatf("sat up%0d count", i), 32'(cnt_s), 32'h9999);
      chk($sformatf("sat up%0d trigg_out", i), 32'(t_s), 32'h1);
      chk($sformatf("sat up%0d digit_trigg", i), 32'(dt_s), 32'h0);
    end
    drive(0, 0, 0, 0, 16'h0);
    chk("sat hold trigg_out", 32'(t_s), 32'h0);
    drive(0, 1, 0, 1, 16'h0000);
    drive(0, 0, 1, 1, 16'h0);
    chk("sat down count", 32'(cnt_s), 32'h0);
    chk("sat down at_limit", 32'(lim_s), 32'h1);
    chk("sat down trigg_out", 32'(t_s), 32'h1);
    drive(1, 0, 0, 0, 16'h0);
    vw = 0;
    vs = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] rv;
      rv = 16'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 3) != 0);
      dn = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) rv = 16'h9999;
      else if ($urandom_range(0, 3) == 0) rv = 16'h0000;
      lv = rv;
      model(0, vw, edw, etw);
      model(1, vs, eds, ets);
      @(posedge clk);
      #1;
      chk("rnd wrap count", 32'(cnt_w), 32'(pack(vw)));
      chk("rnd wrap digit_trigg", 32'(dt_w), 32'(edw));
      chk("rnd wrap trigg_out", 32'(t_w), 32'(etw));
      chk("rnd wrap at_limit", 32'(lim_w), 32'(dn ? vw == 0 : vw == FULL - 1));
      chk("rnd sat count", 32'(cnt_s), 32'(pack(vs)));
      chk("rnd sat digit_trigg", 32'(dt_s), 32'(eds));
      chk("rnd sat trigg_out", 32'(t_s), 32'(ets));
      chk("rnd sat at_limit", 32'(lim_s), 32'(dn ? vs == 0 : vs == FULL - 1));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
